// File: rtl/sifh_peak_reader.sv
// Histogram peak reader: scans each pixel's histogram through SRAM port B and
// reports the bin holding the largest count, one result pulse per pixel.
module sifh_peak_reader #(
    parameter int RAM_ADDR          = 10,
    parameter int NB                = 8,
    parameter int BIN_NUM_PER_HIS   = 256,
    parameter int PIXEL_NUM_PER_RAM = 4,
    parameter int PIX_W             = 2,
    parameter int PEAK_MAX          = 16
) (
    input  logic                clk,
    input  logic                res,
    input  logic                start,
    input  logic [PEAK_MAX-1:0] minCount,
    input  logic [PEAK_MAX-1:0] counts,
    output logic [RAM_ADDR-1:0] raddr,
    output logic                rEnable,
    output logic                readFlag,
    output logic                busy,
    output logic                peakValid,
    output logic [PIX_W-1:0]    peakPixel,
    output logic [NB-1:0]       peakBin,
    output logic [PEAK_MAX-1:0] peakCount,
    output logic                peakFound,
    output logic                findPeakFinish
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, REPORT} state_t;

    state_t              state, state_next;
    logic [NB-1:0]       bin, bin_d;
    logic [PIX_W-1:0]    pixel;
    logic                sample_valid;
    logic [PEAK_MAX-1:0] max_count, min_count;
    logic [NB-1:0]       max_bin;

    logic                last_bin, last_pixel, take;
    logic [PEAK_MAX-1:0] cand_count;
    logic [NB-1:0]       cand_bin;

    assign last_bin   = (bin == NB'(BIN_NUM_PER_HIS - 1));
    assign last_pixel = (pixel == PIX_W'(PIXEL_NUM_PER_RAM - 1));

    // Strict compare keeps the lowest bin on ties; bin_d pairs each count with
    // the address that produced it one cycle earlier.
    assign take       = sample_valid && (counts > max_count);
    assign cand_count = take ? counts : max_count;
    assign cand_bin   = take ? bin_d : max_bin;

    assign readFlag = (state == ISSUE);
    assign rEnable  = 1'b0;
    assign busy     = (state != IDLE);
    assign raddr    = readFlag
                    ? RAM_ADDR'(pixel) * RAM_ADDR'(BIN_NUM_PER_HIS) + RAM_ADDR'(bin)
                    : '0;

    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next; no latch inferred.
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   if (last_bin) state_next = DRAIN;
            DRAIN:   state_next = REPORT;
            REPORT:  state_next = last_pixel ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            bin            <= '0;
            bin_d          <= '0;
            pixel          <= '0;
            sample_valid   <= 1'b0;
            max_count      <= '0;
            max_bin        <= '0;
            min_count      <= '0;
            peakValid      <= 1'b0;
            peakPixel      <= '0;
            peakBin        <= '0;
            peakCount      <= '0;
            peakFound      <= 1'b0;
            findPeakFinish <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            peakValid      <= 1'b0;
            findPeakFinish <= 1'b0;
            sample_valid   <= (state == ISSUE);
            bin_d          <= bin;
            if (take) begin
                max_count <= counts;
                max_bin   <= bin_d;
            end
            case (state)
                IDLE: if (start) begin
                    min_count <= minCount;
                    pixel     <= '0;
                    bin       <= '0;
                    max_count <= '0;
                    max_bin   <= '0;
                end
                ISSUE: if (!last_bin) bin <= bin + NB'(1);
                DRAIN: begin
                    // The final sample arrives during DRAIN, so the result uses the candidate.
                    peakValid      <= 1'b1;
                    peakPixel      <= pixel;
                    peakBin        <= cand_bin;
                    peakCount      <= cand_count;
                    peakFound      <= (cand_count >= min_count);
                    findPeakFinish <= last_pixel;
                end
                REPORT: begin
                    max_count <= '0;
                    max_bin   <= '0;
                    bin       <= '0;
                    if (!last_pixel) pixel <= pixel + PIX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sifh_peak_reader.md
Name: sifh_peak_reader

Overview:
- Read-side counterpart to the histogram builder. After a histogram pass completes, it scans the shared histogram SRAM through port B, pixel by pixel.
- For each pixel it finds the bin with the maximum count and reports bin index, count and pixel number.
- It sits inside the SiFH top next to the histogram builder and is launched in the find-peak states. It drives raddr/rEnable/readFlag, consumes counts, and returns findPeakFinish to the top FSM.

Parameters:
- RAM_ADDR, 10, SRAM address width.
- NB, 8, bin index width.
- BIN_NUM_PER_HIS, 256, bins per pixel histogram (≤ 2^NB).
- PIXEL_NUM_PER_RAM, 4, pixel histograms stored in one SRAM.
- PIX_W, 2, pixel index width.
- PEAK_MAX, 16, histogram count width.

Ports:
- clk  input  1  system clock
- res  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a scan of all pixels
- minCount  input  PEAK_MAX  detection threshold, sampled on accepted start
- counts  input  PEAK_MAX  SRAM port-B read data, valid one cycle after raddr
- raddr  output  RAM_ADDR  SRAM port-B address
- rEnable  output  1  port-B read select, 0 = read
- readFlag  output  1  port-B memory enable, 1 = enabled
- busy  output  1  scan in progress
- peakValid  output  1  one-cycle pulse per pixel result
- peakPixel  output  PIX_W  pixel index of current result
- peakBin  output  NB  bin index of maximum
- peakCount  output  PEAK_MAX  maximum count
- peakFound  output  1  peakCount ≥ minCount
- findPeakFinish  output  1  one-cycle pulse after last pixel

Behaviour:
- Reset (res low, async): state IDLE; all outputs 0 (rEnable 0, readFlag 0); internal max/bin/pixel registers 0.
- SRAM read latency is fixed at 1 cycle. counts during cycle t+1 corresponds to raddr driven in cycle t.
- Address mapping: raddr = pixel*BIN_NUM_PER_HIS + bin, computed at RAM_ADDR width.
- States:
  - IDLE: readFlag 0. On start: latch minCount, pixel=0, bin=0, go ISSUE.
  - ISSUE: readFlag 1, rEnable 0, raddr = current address, bin increments each cycle. After bin BIN_NUM_PER_HIS-1 is issued, go DRAIN.
  - DRAIN: readFlag 0; sample the last count; go REPORT.
  - REPORT: peakValid=1 for 1 cycle with peakPixel/peakBin/peakCount/peakFound. If pixel==PIXEL_NUM_PER_RAM-1, also pulse findPeakFinish and go IDLE. Otherwise pixel+1, bin=0, clear max, go ISSUE.
- Compare rule: a sampled count replaces the running max only if count > max (strict). Ties therefore keep the lowest bin index.
- The running max is initialised to 0 with bin 0. An all-zero histogram reports bin 0, count 0.
- The bin associated with each sample comes from a 1-cycle delayed copy of the issued bin index.
- Timing: start sampled at cycle 0. Addresses go out in cycles 1..N (N=BIN_NUM_PER_HIS), DRAIN is cycle N+1, peakValid is cycle N+2. The next pixel's first address is in cycle N+3. A full scan takes PIXEL_NUM_PER_RAM*(N+2) cycles after start.
- busy=1 from the cycle after start through the final REPORT inclusive.
- peak* outputs hold their last values until the next REPORT. They are only meaningful while peakValid=1.
- start while busy is ignored, with no restart and no minCount re-latch.
- start coincident with the final REPORT is ignored. A new start is accepted only in IDLE.
- peakFound compares with ≥, so minCount=0 makes peakFound always 1.
- Reset asserted mid-scan aborts immediately. readFlag drops asynchronously, no pulse is emitted, and there is no partial result.
- Counts saturated at 2^PEAK_MAX-1 compare normally, with no overflow handling needed.

Test Plan:
- Single peak: pixel 0 bin 37 = 500, others 3; minCount=10 → pixel 0 peakValid at cycle 258 with peakBin=37, peakCount=500, peakFound=1.
- Ties: pixel 1 bins 12 and 200 both = 80 → peakBin=12, peakCount=80.
- Address/timing: check raddr for pixel 2 runs 512..767 in consecutive cycles with readFlag=1 and rEnable=0. Check findPeakFinish occurs exactly 1032 cycles after start, coincident with the pixel 3 peakValid.
- Threshold and empty: all-zero pixel 3 with minCount=5 → peakBin=0, peakCount=0, peakFound=0. Same pixel with minCount=0 → peakFound=1.
- Edges: peak in bin 255 = 65535 → peakBin=255, peakCount=65535. Peak in bin 0 only → peakBin=0.
- Control: start pulsed mid-scan → ignored, scan completes normally. res low mid-pixel-1 → outputs 0 and IDLE. A subsequent start rescans from pixel 0 with correct results.
